// File: rtl/ws_inst_sequencer.sv
// Weight-stationary instruction sequencer: drives the core's 40-bit inst bus through
// per-kij weight load, activation execute, flush and gap, while draining OFIFO into PMEM.
module ws_inst_sequencer #(
    parameter int          COL      = 8,
    parameter int          LEN_KIJ  = 9,
    parameter int          LEN_NIJ  = 36,
    parameter logic [7:0]  W_BASE   = 8'h80,
    parameter logic [7:0]  X_BASE   = 8'h00,
    parameter logic [8:0]  P_BASE   = 9'h000,
    parameter int          GAP_CYC  = 19,
    parameter int          CTRL_LAG = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        l0_ready,
    input  logic        ofifo_valid,
    output logic [39:0] inst,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    localparam int DRAIN_TOTAL = LEN_KIJ * LEN_NIJ;
    localparam int DRN_W       = $clog2(DRAIN_TOTAL + 1);
    localparam int KIJ_W       = (LEN_KIJ > 1) ? $clog2(LEN_KIJ) : 1;
    localparam int IDX_LIM     = (LEN_NIJ > GAP_CYC) ? ((LEN_NIJ > COL) ? LEN_NIJ : COL)
                                                     : ((GAP_CYC > COL) ? GAP_CYC : COL);
    localparam int IDX_W       = (IDX_LIM > 1) ? $clog2(IDX_LIM) : 1;

    // Idle word: every chip enable / write enable deasserted, PMEM address parked at base.
    localparam logic [39:0] INST_IDLE = {1'b0, 1'b0, 1'b1, 1'b1, P_BASE, 1'b1, 8'h00,
                                         1'b1, 1'b1, 8'h00, 8'h00};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_W     = 3'd1,
        S_EXEC_X     = 3'd2,
        S_FLUSH      = 3'd3,
        S_GAP        = 3'd4,
        S_WAIT_DRAIN = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [KIJ_W-1:0]   kij_q, kij_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [8:0]         pmem_addr_q, pmem_addr_d;
    logic [2:0]         lag_q [CTRL_LAG];
    logic [39:0]        inst_q, inst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               drain_full;
    logic               drain_fire;
    logic               lag_empty;
    logic               cen0_d;
    logic [7:0]         a0_d;
    logic [2:0]         ctrl_d;

    assign drain_full = (drain_cnt_q == DRN_W'(DRAIN_TOTAL));
    assign drain_fire = (state_q != S_IDLE) && ofifo_valid && !drain_full;

    always_comb begin
        lag_empty = 1'b1;
        for (int i = 0; i < CTRL_LAG; i++) begin
            if (lag_q[i] != 3'b000) lag_empty = 1'b0;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state and issue counters ----------------
    always_comb begin
        state_d = state_q;
        kij_d   = kij_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_W;
                    kij_d   = '0;
                    idx_d   = '0;
                end
            end
            S_LOAD_W: begin
                if (l0_ready) begin
                    if (idx_q == IDX_W'(COL - 1)) begin
                        idx_d   = '0;
                        state_d = S_EXEC_X;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_EXEC_X: begin
                if (l0_ready) begin
                    if (idx_q == IDX_W'(LEN_NIJ - 1)) begin
                        idx_d   = '0;
                        state_d = S_FLUSH;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                idx_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (idx_q == IDX_W'(GAP_CYC - 1)) begin
                    idx_d = '0;
                    if (kij_q == KIJ_W'(LEN_KIJ - 1)) begin
                        state_d = S_WAIT_DRAIN;
                    end else begin
                        kij_d   = kij_q + KIJ_W'(1);
                        state_d = S_LOAD_W;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_WAIT_DRAIN: begin
                if (drain_full && lag_empty) begin
                    state_d = S_IDLE;
                    kij_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cen0_d = 1'b1;
        a0_d   = 8'h00;
        ctrl_d = 3'b000;
        case (state_q)
            S_LOAD_W: begin
                if (l0_ready) begin
                    cen0_d = 1'b0;
                    a0_d   = W_BASE + 8'(int'(kij_q) * COL) + 8'(idx_q);
                    ctrl_d = 3'b001;
                end
            end
            S_EXEC_X: begin
                if (l0_ready) begin
                    cen0_d = 1'b0;
                    a0_d   = X_BASE + 8'(idx_q);
                    ctrl_d = 3'b010;
                end
            end
            S_FLUSH: ctrl_d = 3'b111;
            default: ;
        endcase

        busy_d = (state_q != S_IDLE) || (state_d != S_IDLE);
        done_d = (state_q == S_WAIT_DRAIN) && (state_d == S_IDLE);

        inst_d        = INST_IDLE;
        inst_d[39]    = busy_d;
        inst_d[37]    = !drain_fire;
        inst_d[36]    = !drain_fire;
        inst_d[35:27] = busy_d ? pmem_addr_q : P_BASE;
        inst_d[17]    = cen0_d;
        inst_d[15:8]  = a0_d;
        inst_d[7]     = drain_fire;
        // L0 write follows a visible XMEM read; L0 read follows the write.
        inst_d[4]     = inst_q[3];
        inst_d[3]     = !inst_q[17] && inst_q[16];
        inst_d[2:0]   = lag_q[CTRL_LAG-1];
    end

    // ---------------- drain engine ----------------
    always_comb begin
        drain_cnt_d = drain_cnt_q;
        pmem_addr_d = pmem_addr_q;
        if (state_q == S_IDLE) begin
            drain_cnt_d = '0;
            pmem_addr_d = P_BASE;
        end else if (drain_fire) begin
            drain_cnt_d = drain_cnt_q + DRN_W'(1);
            pmem_addr_d = pmem_addr_q + 9'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kij_q       <= '0;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            pmem_addr_q <= P_BASE;
        end else begin
            kij_q       <= kij_d;
            idx_q       <= idx_d;
            drain_cnt_q <= drain_cnt_d;
            pmem_addr_q <= pmem_addr_d;
        end
    end

    // Control bits trail their XMEM fields to line up with SRAM + L0 latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CTRL_LAG; i++) lag_q[i] <= 3'b000;
        end else begin
            lag_q[0] <= ctrl_d;
            for (int i = 1; i < CTRL_LAG; i++) lag_q[i] <= lag_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_q <= INST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            inst_q <= inst_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign inst      = inst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ws_inst_sequencer.sv
// Directed bench for ws_inst_sequencer: reset values, cycle-exact first kij,
// stalled issue ordering, PMEM drain addressing and the single done pulse.
module tb_ws_inst_sequencer;

  localparam logic [39:0] INST_IDLE = 40'h30_0403_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        l0_ready;
  logic        ofifo_valid;
  logic [39:0] inst;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [8:0] pexp_q[$];

  ws_inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .l0_ready    (l0_ready),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Run-1 timing (l0_ready held high, start accepted before negedge 1):
  // XMEM issues visible at negedges 2..45 and 66, flush slot at 46.
  function automatic bit issue1(input int c);
    return (c >= 2 && c <= 45) || (c == 66);
  endfunction

  function automatic logic [39:0] exp_word1(input int c);
    logic [7:0] a0;
    logic [2:0] ctrl;
    int s;
    a0 = 8'h00;
    if (c >= 2 && c <= 9) a0 = 8'(8'h80 + c - 2);
    else if (c >= 10 && c <= 45) a0 = 8'(c - 10);
    else if (c == 66) a0 = 8'h88;
    s = c - 2;
    ctrl = 3'b000;
    if (s >= 2 && s <= 9) ctrl = 3'b001;
    else if (s >= 10 && s <= 45) ctrl = 3'b010;
    else if (s == 46) ctrl = 3'b111;
    return {1'b1, 1'b0, 1'b1, 1'b1, 9'd0, 1'b1, 8'h00, !issue1(c), 1'b1, a0,
            1'b0, 2'b00, issue1(c - 2), issue1(c - 1), ctrl};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic prev_ready;
    logic prev_valid;
    logic exp_rd;
    int   drained;
    int   done_cnt;

    reset = 1'b1;
    start = 1'b0;
    l0_ready = 1'b0;
    ofifo_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_inst", inst, INST_IDLE);
    check("reset_busy", 40'(busy), 40'd0);
    check("reset_done", 40'(done), 40'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_inst", inst, INST_IDLE);

    // Run 1: full-speed kij0, a start pulse while busy, then reset inside kij3 LOAD_W.
    l0_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      start = (c == 30);
      check($sformatf("t2_inst_c%0d", c), inst, exp_word1(c));
      check($sformatf("t2_busy_c%0d", c), 40'(busy), 40'd1);
      check($sformatf("t2_done_c%0d", c), 40'(done), 40'd0);
    end
    for (int c = 67; c <= 196; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t1_kij3_a0", 40'(inst[17:8]), 40'({2'b01, 8'h9A}));
    reset = 1'b1;
    #1;
    check("t1_reset_inst", inst, INST_IDLE);
    check("t1_reset_busy", 40'(busy), 40'd0);
    check("t1_reset_done", 40'(done), 40'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t1_after_done", 40'(done), 40'd0);
    end
    check("t1_after_inst", inst, INST_IDLE);
    check("t1_after_busy", 40'(busy), 40'd0);

    // Run 2: toggling l0_ready, periodic ofifo_valid, start pulse during busy.
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h80 + 8 * k + i));
      for (int j = 0; j < 36; j++) exp_q.push_back(8'(j));
    end
    for (int p = 0; p < 324; p++) pexp_q.push_back(9'(p));

    drained = 0;
    done_cnt = 0;
    l0_ready = 1'b1;
    ofifo_valid = 1'b0;
    start = 1'b1;
    prev_ready = 1'b1;
    prev_valid = 1'b0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      start = (cyc == 100);
      if (inst[17] == 1'b0) begin
        if (exp_q.size() == 0) check("t3_extra_issue", 40'd1, 40'd0);
        else check("t3_a0", 40'(inst[15:8]), 40'(exp_q.pop_front()));
      end
      if (!prev_ready) check("t3_stall_cen0", 40'(inst[17]), 40'd1);
      exp_rd = prev_valid && (drained < 324);
      check("t4_ofifo_rd", 40'(inst[7]), 40'(exp_rd));
      if (inst[7]) begin
        if (pexp_q.size() == 0) check("t4_extra_write", 40'd1, 40'd0);
        else check("t4_pmem", 40'(inst[37:27]), 40'({2'b00, pexp_q.pop_front()}));
        drained++;
      end
      if (done) begin
        done_cnt++;
        check("t5_drained_at_done", 40'(drained), 40'd324);
        check("t5_busy_at_done", 40'(busy), 40'd1);
        break;
      end
      l0_ready = ~l0_ready;
      ofifo_valid = busy && (cyc % 3 != 0);
      prev_ready = l0_ready;
      prev_valid = ofifo_valid;
    end
    if (done_cnt == 0) check("t5_done_timeout", 40'd0, 40'd1);

    // Extra OFIFO data after completion must be ignored and done must not repeat.
    ofifo_valid = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("t5_post_inst", inst, INST_IDLE);
    check("t5_post_busy", 40'(busy), 40'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_single_done", 40'(done), 40'd0);
      check("t5_no_rd_idle", 40'(inst[7]), 40'd0);
    end
    check("t3_queue_empty", 40'(exp_q.size()), 40'd0);
    check("t4_queue_empty", 40'(pexp_q.size()), 40'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
